uart_tx_scheduler: RTL

Round-robin scheduler that shares one UART_Transmitter between four byte requesters. It accepts a byte from one requester at a time and drives the transmitter's tx_datavalid/Byte_to_transmit inputs. It then waits for tx_complete, reports completion to the owning requester, and enforces an inter-frame gap before the next grant. It sits between the four byte sources and the single transmitter instance.

---
 rtl/uart_tx_scheduler.sv | 138 +++++++++++++
 1 files changed

// File: rtl/uart_tx_scheduler.sv
// Round-robin arbiter sharing one UART transmitter among four byte requesters.
// Optional WAIT_DONE watchdog is built when UART_TX_TIMEOUT_EN is defined.
module uart_tx_scheduler #(
    parameter int unsigned GAP_CYCLES     = 2,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic        MasterClk,
    input  logic        Reset_n,
    input  logic [3:0]  req_valid,
    input  logic [31:0] req_data,
    output logic [3:0]  req_grant,
    output logic [3:0]  req_done,
    output logic        busy,
    output logic        tx_datavalid,
    output logic [7:0]  Byte_to_transmit,
    input  logic        tx_active,
    input  logic        tx_complete,
    output logic        timeout_err
);

    localparam int unsigned GAP_W = 8;
    localparam int unsigned TO_W  = 16;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LAUNCH    = 2'd1,
        WAIT_DONE = 2'd2,
        GAP       = 2'd3
    } state_t;

    state_t             state;
    logic [1:0]         rr;
    logic [1:0]         cur;
    logic [GAP_W-1:0]   gap_cnt;
    logic [1:0]         sel;
    logic [1:0]         cand;
    logic               sel_found;
    logic [7:0]         sel_byte;

    // Transmitter status is informational only; sequencing relies on tx_complete.
    logic unused_tx_active;
    assign unused_tx_active = tx_active;

    // Cyclic search starting just after the last grantee.
    always_comb begin
        sel       = rr;
        cand      = rr;
        sel_found = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            cand = 2'(rr + 2'(k));
            if (!sel_found && req_valid[cand]) begin
                sel       = cand;
                sel_found = 1'b1;
            end
        end
    end

    assign sel_byte = req_data[{sel, 3'b000} +: 8];

`ifdef UART_TX_TIMEOUT_EN
    logic [TO_W-1:0] to_cnt;
`else
    assign timeout_err = 1'b0;
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = ^TO_W'(TIMEOUT_CYCLES);
`endif

    always_ff @(posedge MasterClk or negedge Reset_n) begin
        if (!Reset_n) begin
            state            <= IDLE;
            rr               <= 2'd3;
            cur              <= 2'd0;
            gap_cnt          <= '0;
            req_grant        <= '0;
            req_done         <= '0;
            busy             <= 1'b0;
            tx_datavalid     <= 1'b0;
            Byte_to_transmit <= '0;
`ifdef UART_TX_TIMEOUT_EN
            to_cnt           <= '0;
            timeout_err      <= 1'b0;
`endif
        end else begin
            req_grant    <= '0;
            req_done     <= '0;
            tx_datavalid <= 1'b0;
`ifdef UART_TX_TIMEOUT_EN
            timeout_err  <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (sel_found) begin
                        state            <= LAUNCH;
                        busy             <= 1'b1;
                        tx_datavalid     <= 1'b1;
                        Byte_to_transmit <= sel_byte;
                        req_grant        <= 4'b0001 << sel;
                        cur              <= sel;
                        rr               <= sel;
                    end
                end
                LAUNCH: begin
                    state <= WAIT_DONE;
`ifdef UART_TX_TIMEOUT_EN
                    to_cnt <= '0;
`endif
                end
                WAIT_DONE: begin
                    // Only the first tx_complete cycle is seen; the second lands in GAP.
                    if (tx_complete) begin
                        req_done <= 4'b0001 << cur;
                        gap_cnt  <= '0;
                        state    <= GAP;
                    end
`ifdef UART_TX_TIMEOUT_EN
                    else if (to_cnt == TO_W'(TIMEOUT_CYCLES - 1)) begin
                        timeout_err <= 1'b1;
                        gap_cnt     <= '0;
                        state       <= GAP;
                    end else begin
                        to_cnt <= to_cnt + TO_W'(1);
                    end
`endif
                end
                GAP: begin
                    if (gap_cnt == GAP_W'(GAP_CYCLES)) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        gap_cnt <= gap_cnt + GAP_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
